// File: rtl/recovery_pkg.sv
// Shared constants for the recovery ROM fetch path.
//   ROM_SIZE_DEF  : default ROM depth in 32-bit words
//   BASE_ADDR_DEF : default byte address of ROM word 0
//   INSTR_NOP / INSTR_DRET : encodings placed in the recovery image
//   CORE0 / CORE1 : per-core index into the 2-bit request/grant vectors
package recovery_pkg;

    localparam int unsigned ROM_SIZE_DEF  = 32;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0000;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0] INSTR_DRET = 32'h7b20_0073;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter for the lockstep cores' fetch ports.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset; grants are held off while low
//   enable_i : grants only issued while high
//   req_i    : request per core
//   gnt_o    : one-hot (or zero) grant, combinational from req_i
// The priority pointer names the core that wins a tie; it flips to the
// other core after every grant and holds when nothing is granted.
module rr_arbiter2
    import recovery_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;

    always_comb begin
        gnt_o = 2'b00;
        if (rst_ni && enable_i) begin
            if (req_i[CORE0] && (!req_i[CORE1] || ptr_q == CORE0))
                gnt_o[CORE0] = 1'b1;
            else if (req_i[CORE1])
                gnt_o[CORE1] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            ptr_q <= CORE0;
        else if (gnt_o[CORE0])
            ptr_q <= CORE1;
        else if (gnt_o[CORE1])
            ptr_q <= CORE0;
    end

endmodule

// File: rtl/recovery_rom_arbiter.sv
// Shares the recovery code ROM between the two lockstep cores' fetch ports.
//   clk_i, rst_ni       : clock, synchronous active-low reset
//   enable_i            : recovery window open; no new grants while low
//   req_i, addr_i       : per-core fetch request and byte address
//   gnt_o               : per-core grant, same cycle as the accepted request
//   rvalid_o, rdata_o   : per-core response, one cycle after the grant
//   err_o               : per-core out-of-window flag, qualified by rvalid_o
//   rom_req_o/addr_o    : ROM request and byte offset from BASE_ADDR
//   rom_rdata_i         : ROM data, valid the cycle after rom_req_o
module recovery_rom_arbiter
    import recovery_pkg::*;
#(
    parameter int unsigned ROM_SIZE  = ROM_SIZE_DEF,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic [1:0]      req_i,
    input  logic [1:0][31:0] addr_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      rvalid_o,
    output logic [1:0][31:0] rdata_o,
    output logic [1:0]      err_o,
    output logic            rom_req_o,
    output logic [31:0]     rom_addr_o,
    input  logic [31:0]     rom_rdata_i
);

    // Upper bound kept at 33 bits so a window ending at 2^32 does not wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(ROM_SIZE) << 2);

    logic [1:0]  gnt;
    logic        any_gnt;
    logic [31:0] sel_addr;
    logic        in_win;
    logic [1:0]  vld_q;
    logic        err_q;

    rr_arbiter2 u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .req_i    (req_i),
        .gnt_o    (gnt)
    );

    assign gnt_o    = gnt;
    assign any_gnt  = |gnt;
    assign sel_addr = gnt[CORE1] ? addr_i[CORE1] : addr_i[CORE0];
    assign in_win   = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);

    // Out-of-window fetches are still granted but leave the ROM untouched.
    assign rom_req_o  = any_gnt & in_win;
    assign rom_addr_o = any_gnt ? (sel_addr - BASE_ADDR) : 32'h0;

    // Only one core is granted per cycle, so a single error bit suffices.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= 2'b00;
            err_q <= 1'b0;
        end else begin
            vld_q <= gnt;
            err_q <= any_gnt & ~in_win;
        end
    end

    // Gating with rst_ni drops a response still in flight when reset hits.
    assign rvalid_o = vld_q & {2{rst_ni}};

    for (genvar g = 0; g < 2; g++) begin : g_resp
        assign rdata_o[g] = (rvalid_o[g] && !err_q) ? rom_rdata_i : 32'h0;
        assign err_o[g]   = rvalid_o[g] & err_q;
    end

endmodule

// File: doc/recovery_rom_arbiter.md
Name: recovery_rom_arbiter

Overview:
- Shares the single recovery code ROM between the two lockstep cores' instruction-fetch ports during fault recovery.
- Arbitrates fetch requests round-robin and drives the ROM's req/addr.
- Routes the ROM's one-cycle-later data back to the granted core with an rvalid pulse.
- Flags fetches outside the ROM window and returns zero data for them.

Parameters:
- ROM_SIZE, 32, ROM depth in 32-bit words; must match the ROM instance.
- BASE_ADDR, 32'h0000_0000, byte address of ROM word 0 in the core address map; word-aligned.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- enable_i  in  1  recovery window open; no new grants while 0
- req_i  in  2  fetch request per core (index 0 = core0, 1 = core1)
- addr_i  in  2x32  byte fetch address per core
- gnt_o  out  2  grant per core, combinational, same cycle as accepted req
- rvalid_o  out  2  response valid per core, one cycle after that core's grant
- rdata_o  out  2x32  response data per core; valid only with rvalid_o
- err_o  out  2  out-of-window flag, qualified by rvalid_o
- rom_req_o  out  1  to ROM req_i
- rom_addr_o  out  32  to ROM addr_i, byte offset from BASE_ADDR
- rom_rdata_i  in  32  from ROM rdata_o, valid the cycle after rom_req_o

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - rvalid_o=0, err_o=0, rdata_o=0.
  - Priority pointer = core0.
  - Any outstanding response is discarded.
  - gnt_o and rom_req_o are forced 0 while rst_ni=0.
- Grant rule, combinational:
  - At most one gnt_o bit high per cycle.
  - A grant is given only when enable_i=1.
  - Single requester: that requester is granted.
  - Both requesting: the core named by the priority pointer wins.
  - A losing core must hold req_i and addr_i stable until granted (OBI rule); the arbiter does not latch requests.
- Pointer update: on any grant to core i, the pointer moves to core 1-i next cycle. With no grant the pointer is unchanged.
- ROM drive:
  - rom_req_o = OR of gnt_o.
  - rom_addr_o = granted addr_i - BASE_ADDR (32-bit wrap arithmetic). When nothing is granted, rom_addr_o = 0.
- Window check: a fetch is in-window iff BASE_ADDR <= addr < BASE_ADDR + 4*ROM_SIZE, evaluated with 33-bit compare so the upper bound does not wrap.
- Out-of-window fetch:
  - Still granted, but rom_req_o = 0 for that cycle so the ROM's address register is untouched.
  - Response cycle: rdata_o=0, err_o=1.
- Response pipeline:
  - Register per-core valid bits and a pending-error bit on grant.
  - Next cycle: rvalid_o[i]=1 for exactly one cycle; rdata_o[i]=rom_rdata_i when in-window.
  - Latency is fixed at 1; back-to-back grants (including alternating cores) are sustained at 1 fetch/cycle.
- Non-selected core: rdata_o is driven 0 when its rvalid_o=0.
- enable_i falling with a response outstanding: that response is still delivered next cycle; only new grants are blocked.
- Misaligned addr: low two bits are ignored (the ROM drops them); no error is raised.
- No FSM beyond the pointer and the response registers.

Decomposition:
- Shared package (recovery_pkg): ROM_SIZE default, BASE_ADDR default, NOP encoding 32'h0000_0013, DRET encoding 32'h7b20_0073, core index constants.
- One natural sub-module: rr_arbiter2. It contains the 2-way round-robin grant and pointer register, with inputs req/enable and outputs gnt.
- Window check, address mux and response registers stay in the top.

Test Plan:
1. Reset, then core0 alone at addr BASE+0x0 → gnt_o=01 same cycle, rom_req_o=1, rom_addr_o=0. Next cycle rvalid_o=01, rdata_o[0]=32'h02a10113, err_o=0.
2. Both cores request every cycle at BASE+0xC → grants alternate 01,10,01,… starting core0. Each rvalid follows by one cycle with 32'h7b200073.
3. Core1 at BASE+4*ROM_SIZE (0x80) → gnt_o=10, rom_req_o=0. Next cycle rvalid_o=10, rdata_o[1]=0, err_o=10.
4. enable_i=0 with both requesting → gnt_o=00 and rom_req_o=0 for all cycles. Then enable_i drops in the same cycle as a grant → the rvalid for that grant still arrives next cycle.
5. rst_ni=0 asserted the cycle after a grant → no rvalid_o in the following cycle. After release, the pointer is core0 (both request → gnt_o=01).
6. Core0 at BASE-4 with BASE_ADDR=32'h1A00_0000 → err_o[0]=1, rdata 0. Check the wrap-safe compare at addr=32'hFFFF_FFFC.
